uart_echo_bridge: RTL and testbench
===================================

UART_ECHO_BRIDGE -- requirements
Module: uart_echo_bridge

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 19200, line bit rate.
REQ-003 SHALL have parameter DBIT, default 8, data bits per frame (5..8).
REQ-004 SHALL have parameter FIFO_AW, default 2, FIFO address width; each FIFO depth = 2**FIFO_AW.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 rx  input  1  serial line in, idle high.
REQ-008 tx  output  1  serial line out, idle high.
REQ-009 echo_en  input  1  1 = every received frame is retransmitted automatically.
REQ-010 wr  input  1  host push into TX FIFO.
REQ-011 w_data  input  DBIT  host TX data.
REQ-012 rd  input  1  host pop from RX FIFO.
REQ-013 r_data  output  DBIT  RX FIFO head, valid while rx_empty=0.
REQ-014 rx_empty, tx_full  output  1 each  FIFO status.
REQ-015 rx_ovf  output  1  sticky RX overflow flag.
REQ-016 perr  output  1  sticky parity error flag (UART_PARITY_EN only, else tied 0).

Function
REQ-017 Oversample tick SHALL pulse one clk every DIV = CLK_FREQ/(16*BAUD) clocks, integer division (162 at defaults).
REQ-018 RX FSM states IDLE, START, DATA, [PARITY], STOP; IDLE->START on rx=0; START samples at tick 7; rx=1 at tick 7 SHALL return to IDLE (glitch reject).
REQ-019 RX SHALL shift data LSB first, sampling every 16 ticks; STOP sampled once, then frame is pushed to RX FIFO in the same cycle STOP completes.
REQ-020 A stop bit sampled 0 SHALL discard the frame with no FIFO push.
REQ-021 TX FSM states IDLE, START, DATA, [PARITY], STOP, each bit 16 ticks; IDLE->START when TX FIFO non-empty, popping head on that transition.
REQ-022 FIFOs SHALL be synchronous, first-word fall-through, pointer wrap modulo depth, full/empty from an extra pointer bit.
REQ-023 rd while rx_empty=1 SHALL be ignored; wr while tx_full=1 SHALL be ignored.
REQ-024 RX push while RX FIFO full SHALL drop the new frame and set rx_ovf; simultaneous rd and push on full SHALL accept both, no overflow.
REQ-025 echo_en=1: each accepted RX frame SHALL also be pushed into TX FIFO; host wr in the same cycle SHALL be ignored (echo has priority); host wr in other cycles accepted.
REQ-026 Echo push while TX FIFO full SHALL be dropped silently; the RX FIFO copy is unaffected.
REQ-027 echo_en change mid-frame SHALL take effect only at the next STOP completion.
REQ-028 Sticky flags SHALL clear only on reset.

Reset
REQ-029 On rst=0, asynchronously: both FSMs IDLE, tick counter 0, FIFOs empty (rx_empty=1, tx_full=0), tx=1, rx_ovf=0, perr=0, r_data=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; the in-flight byte is lost, no partial push.
REQ-031 After rst deasserts, first tick SHALL occur DIV clocks later.

Configuration
REQ-032 Macro UART_PARITY_EN defined: PARITY state inserted in both FSMs, even parity over DBIT bits; RX parity mismatch SHALL set perr and still push the frame.
REQ-033 UART_PARITY_EN undefined: no PARITY state, frame = start + DBIT + stop, perr constant 0.

Verification
REQ-034 Host wr 0xA5, echo_en=0 -> tx frame 0,1,0,1,0,0,1,0,1,1 at 16*DIV clocks per bit; tx_full never set.
REQ-035 rx frame 0x3C, echo_en=1 -> rx_empty falls at stop completion, r_data=0x3C, identical frame appears on tx.
REQ-036 5 frames 0x01..0x05 on rx, no rd, depth 4 -> rx_ovf=1, successive rd return 0x01..0x04 then rx_empty=1.
REQ-037 rx low pulse of 3 ticks -> no push, FSM back to IDLE, rx_empty stays 1.
REQ-038 rst=0 at mid-DATA of TX 0xFF -> tx=1 immediately, tx_full=0, no further frame after release.
REQ-039 UART_PARITY_EN, rx 0x07 with parity bit 0 -> perr=1, r_data=0x07.

Source files
------------

// File: rtl/uart_echo_bridge.sv
// UART bridge with RX/TX FIFOs and optional automatic echo of received frames.
// Optional feature macro: UART_PARITY_EN (even parity bit in both directions).
module uart_echo_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          empty,
  output logic          full
);
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          do_pop;
  logic          do_push;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push on full is still taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign r_data  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= w_data;
        wp              <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

module uart_echo_bridge #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 19200,
  parameter int DBIT     = 8,
  parameter int FIFO_AW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic            tx,
  input  logic            echo_en,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            tx_full,
  output logic            rx_ovf,
  output logic            perr
);
  localparam int DIV = CLK_FREQ / (16 * BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  logic [CW-1:0]   cnt;
  logic            tick;
  state_t          rx_state;
  logic [3:0]      rx_s;
  logic [2:0]      rx_n;
  logic [DBIT-1:0] rx_b;
  logic            rx_done;
  logic            rx_full;
  state_t          tx_state;
  logic [3:0]      tx_s;
  logic [2:0]      tx_n;
  logic [DBIT-1:0] tx_b;
  logic            tx_empty;
  logic            tx_pop;
  logic [DBIT-1:0] tx_head;
  logic            echo_push;
  logic            txf_push;
  logic [DBIT-1:0] txf_data;

  // Oversample tick generator, one pulse per DIV clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

  assign rx_done = (rx_state == S_STOP) && tick && (rx_s == 4'd15) && rx;

  // Receiver: mid-bit sampling, start glitch rejection, framing check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_s     <= 4'd0;
      rx_n     <= 3'd0;
      rx_b     <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (!rx) begin
            rx_state <= S_START;
            rx_s     <= 4'd0;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s == 4'd7) begin
              rx_s     <= 4'd0;
              rx_n     <= 3'd0;
              rx_state <= rx ? S_IDLE : S_DATA;
            end else begin
              rx_s <= rx_s + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (rx_s == 4'd15) begin
              rx_s <= 4'd0;
              rx_b <= {rx, rx_b[DBIT-1:1]};
              if (rx_n == 3'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                rx_state <= S_PAR;
`else
                rx_state <= S_STOP;
`endif
              end else begin
                rx_n <= rx_n + 3'd1;
              end
            end else begin
              rx_s <= rx_s + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (tick) begin
            if (rx_s == 4'd15) begin
              rx_s     <= 4'd0;
              rx_state <= S_STOP;
            end else begin
              rx_s <= rx_s + 4'd1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (rx_s == 4'd15) rx_state <= S_IDLE;
            else               rx_s     <= rx_s + 4'd1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  logic perr_q;

  // Sticky parity error; the frame itself is still delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perr_q <= 1'b0;
    else if (rx_state == S_PAR && tick && rx_s == 4'd15 && (rx != ^rx_b)) perr_q <= 1'b1;
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  // Sticky overflow: a frame arrived with the RX FIFO full and no host pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_ovf <= 1'b0;
    else if (rx_done && rx_full && !rd) rx_ovf <= 1'b1;
  end

  // Echo wins over a host write in the same cycle.
  assign echo_push = rx_done && echo_en;
  assign txf_push  = echo_push || wr;
  assign txf_data  = echo_push ? rx_b : w_data;
  assign tx_pop    = (tx_state == S_IDLE) && !tx_empty;

  uart_echo_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_done), .pop(rd), .w_data(rx_b),
    .r_data(r_data), .empty(rx_empty), .full(rx_full)
  );

  uart_echo_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(txf_push), .pop(tx_pop), .w_data(txf_data),
    .r_data(tx_head), .empty(tx_empty), .full(tx_full)
  );

`ifdef UART_PARITY_EN
  logic tx_par;
`endif

  // Transmitter: tx is registered and changes only on bit boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_s     <= 4'd0;
      tx_n     <= 3'd0;
      tx_b     <= '0;
      tx       <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!tx_empty) begin
            tx_state <= S_START;
            tx_b     <= tx_head;
            tx_s     <= 4'd0;
            tx       <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            if (tx_s == 4'd15) begin
              tx_s     <= 4'd0;
              tx_n     <= 3'd0;
              tx_state <= S_DATA;
              tx       <= tx_b[0];
            end else begin
              tx_s <= tx_s + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tx_s == 4'd15) begin
              tx_s <= 4'd0;
              tx_b <= {1'b0, tx_b[DBIT-1:1]};
              if (tx_n == 3'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                tx_state <= S_PAR;
                tx       <= tx_par;
`else
                tx_state <= S_STOP;
                tx       <= 1'b1;
`endif
              end else begin
                tx_n <= tx_n + 3'd1;
                tx   <= tx_b[1];
              end
            end else begin
              tx_s <= tx_s + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PAR: begin
          if (tick) begin
            if (tx_s == 4'd15) begin
              tx_s     <= 4'd0;
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_s <= tx_s + 4'd1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (tx_s == 4'd15) tx_state <= S_IDLE;
            else               tx_s     <= tx_s + 4'd1;
          end
        end
        default: begin
          tx_state <= S_IDLE;
          tx       <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_echo_bridge.sv
// Self-checking bench for uart_echo_bridge: queue model of both FIFOs plus a
// line-level TX frame monitor; UART_PARITY_EN adds the parity-error scenario.
module tb_uart_echo_bridge;
  localparam int CLK_FREQ = 64;
  localparam int BAUD     = 1;
  localparam int DBIT     = 8;
  localparam int AW       = 2;
  localparam int DIV      = CLK_FREQ / (16 * BAUD);
  localparam int BITC     = 16 * DIV;
`ifdef UART_PARITY_EN
  localparam int NB = DBIT + 3;
`else
  localparam int NB = DBIT + 2;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic            tx;
  logic            echo_en;
  logic            wr;
  logic [DBIT-1:0] w_data;
  logic            rd;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            tx_full;
  logic            rx_ovf;
  logic            perr;

  uart_echo_bridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DBIT(DBIT), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .echo_en(echo_en), .wr(wr),
    .w_data(w_data), .rd(rd), .r_data(r_data), .rx_empty(rx_empty),
    .tx_full(tx_full), .rx_ovf(rx_ovf), .perr(perr)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   rxq[$];
  logic [7:0]   exp_tx[$];
  bit           m_ovf = 1'b0;
  bit           m_perr = 1'b0;
  bit           check_en = 1'b0;
  bit           seen_full = 1'b0;
  int           tx_frames = 0;
  logic [NB-1:0] cap;
  logic [NB-1:0] last_cap;
  bit           aborted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line sequence for one byte, index 0 = first bit on the wire.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Per-cycle comparison of the host-visible RX side against the queue model.
  always @(negedge clk) begin
    if (check_en) begin
      check("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
      if (rxq.size() != 0) check("r_data", 32'(r_data), 32'(rxq[0]));
      check("rx_ovf", 32'(rx_ovf), 32'(m_ovf));
      check("perr", 32'(perr), 32'(m_perr));
    end
    if (tx_full) seen_full = 1'b1;
  end

  // TX line monitor: samples each bit near its middle and scores whole frames.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        for (int i = 0; i < NB; i++) begin
          repeat ((i == 0) ? BITC / 2 : BITC) begin
            @(negedge clk);
            if (!rst) aborted = 1'b1;
          end
          cap[i] = tx;
        end
        if (!aborted) begin
          tx_frames++;
          last_cap = cap;
          if (exp_tx.size() == 0) check("tx_unexpected", 32'(cap), 32'(0));
          else check("tx_frame", 32'(cap), 32'(frame_bits(exp_tx.pop_front())));
        end
      end
    end
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit bad_par);
    check_en = 1'b0;
    tick_clk(1);
    rx = 1'b0;
    tick_clk(BITC);
    for (int i = 0; i < DBIT; i++) begin
      rx = d[i];
      tick_clk(BITC);
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ bad_par;
    tick_clk(BITC);
    if (bad_par) m_perr = 1'b1;
`endif
    rx = 1'b1;
    tick_clk(BITC);
    if (rxq.size() < 4) rxq.push_back(d);
    else m_ovf = 1'b1;
    if (echo_en) exp_tx.push_back(d);
    check_en = 1'b1;
  endtask

  task automatic host_wr(input logic [7:0] d);
    tick_clk(1);
    wr = 1'b1;
    w_data = d;
    tick_clk(1);
    wr = 1'b0;
  endtask

  task automatic host_rd();
    check_en = 1'b0;
    tick_clk(1);
    rd = 1'b1;
    tick_clk(1);
    rd = 1'b0;
    if (rxq.size() != 0) void'(rxq.pop_front());
    check_en = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (tx_frames < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("wait_frames", 32'(tx_frames >= n), 32'd1);
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; echo_en = 1'b0; wr = 1'b0; w_data = '0; rd = 1'b0;
    tick_clk(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_ovf", 32'(rx_ovf), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
    rst = 1'b1;
    check_en = 1'b1;

    // Host byte out, no echo.
    seen_full = 1'b0;
    exp_tx.push_back(8'hA5);
    host_wr(8'hA5);
    wait_frames(1);
`ifndef UART_PARITY_EN
    check("a5_line", 32'(last_cap), 32'(10'b1101001010));
`endif
    check("a5_no_full", 32'(seen_full), 32'd0);

    // Received byte is delivered to the host and echoed on tx.
    echo_en = 1'b1;
    send_rx(8'h3C, 1'b0);
    check("3c_rx_empty", 32'(rx_empty), 32'd0);
    check("3c_r_data", 32'(r_data), 32'h3C);
    wait_frames(2);
`ifndef UART_PARITY_EN
    check("3c_echo_line", 32'(last_cap), 32'(10'b1001111000));
`endif
    host_rd();
    check("3c_drained", 32'(rx_empty), 32'd1);
    echo_en = 1'b0;

    // Short start glitch is rejected.
    rx = 1'b0;
    tick_clk(3 * DIV);
    rx = 1'b1;
    tick_clk(2 * BITC);
    check("glitch_rx_empty", 32'(rx_empty), 32'd1);

    // Five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b0);
    check("ovf_set", 32'(rx_ovf), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", 32'(r_data), 32'(i));
      host_rd();
    end
    check("ovf_drained", 32'(rx_empty), 32'd1);

    // TX FIFO fill: one byte in flight, four queued, sixth write dropped.
    exp_tx.push_back(8'h11);
    host_wr(8'h11);
    tick_clk(5);
    for (int i = 2; i <= 6; i++) begin
      if (i <= 5) exp_tx.push_back(8'(i * 17));
      host_wr(8'(i * 17));
    end
    check("tx_full_set", 32'(tx_full), 32'd1);
    wait_frames(7);
    check("tx_full_clear", 32'(tx_full), 32'd0);

    // Reset in the middle of a TX frame.
    host_wr(8'hFF);
    tick_clk(BITC / 2 + 4 * BITC);
    check_en = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_tx_full", 32'(tx_full), 32'd0);
    check("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
    check("mid_rst_rx_ovf", 32'(rx_ovf), 32'd0);
    rxq.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
    tick_clk(3);
    rst = 1'b1;
    check_en = 1'b1;
    tick_clk(12 * BITC);
    check("mid_rst_no_frame", 32'(tx_frames), 32'd7);

`ifdef UART_PARITY_EN
    send_rx(8'h07, 1'b1);
    check("par_perr", 32'(perr), 32'd1);
    check("par_r_data", 32'(r_data), 32'h07);
`endif

    check("tx_all_seen", 32'(exp_tx.size()), 32'd0);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
